adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter and sequencer sharing one 32-bit recursive-doubling adder (`RecursiveDoubling`) among NREQ requesters in the floating-point addition datapath. It grants one requester per cycle and muxes that requester's operands into the adder. The sum and carry-out are captured in a single output register with a valid/ready handshake and tagged with the requester index.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: width of `rsp_id`, equal to ceil(log2(NREQ)).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: bit i set means requester i presents an operation.
- `req_a` input NREQ*32: operand A; requester i occupies bits [32i+31:32i].
- `req_b` input NREQ*32: operand B, packed the same way as `req_a`.
- `req_lock` input NREQ: lock request, used only with `ADDER_ARB_LOCK_EN`.
- `req_ready` output NREQ: one-hot or zero; accept strobe for the granted requester.
- `rsp_valid` output 1: output register holds a result.
- `rsp_ready` input 1: downstream accepts the result.
- `rsp_id` output IDW: index of the requester that produced the result.
- `rsp_sum` output 32: A+B mod 2^32.
- `rsp_carry` output 1: carry-out of bit 31.
- `ops_count` output 16: count of completed responses; wraps.

## Operation
- Output register FSM has two states.
  - EMPTY (`rsp_valid`=0).
  - FULL (`rsp_valid`=1).
- `can_accept` = EMPTY, or (FULL and `rsp_ready`).
- Round-robin pointer `ptr` (IDW bits). Winner `g` is the first set `req_valid` bit scanning ptr, ptr+1, …, wrapping modulo NREQ.
- `req_ready[g]` = `can_accept` and any `req_valid`. All other `req_ready` bits are 0. `req_ready` is combinational from `req_valid` and state.
- Accept happens when `req_valid[g]` and `req_ready[g]` are both high at a rising edge. On accept:
  - `rsp_sum` and `rsp_carry` load from the adder driven by `req_a[g]` and `req_b[g]`.
  - `rsp_id` loads `g`.
  - State becomes FULL.
  - `ptr` loads (g+1) mod NREQ.
- Drain without accept (FULL, `rsp_ready`=1, no accept): state becomes EMPTY and data registers hold.
- Drain and accept in the same edge: state stays FULL with the new data. This gives one result per cycle.
- `ops_count` increments on every edge where `rsp_valid` and `rsp_ready` are both high. It wraps from 0xFFFF to 0.
- `ptr` does not move when nothing is accepted.
- A requester must hold `req_a`, `req_b` and `req_lock` stable while `req_valid` is high and not yet accepted.
- Sum width rule: `rsp_sum` = (A+B)[31:0] and `rsp_carry` = (A+B)[32], both unsigned.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_carry`=0, `ops_count`=0, `ptr`=0, lock cleared, `req_ready`=0.
- `rst` wins over every simultaneous event. An in-flight result is discarded and not counted.
- Latency: an accept at edge k gives `rsp_valid`=1 during cycle k+1.
- The adder is purely combinational between the operand mux and the output register. There is one pipeline stage in total.
- Full back-pressure: with `rsp_ready`=0 and state FULL, `req_ready`=0 and all outputs hold.
- Throughput: one operation per cycle while `rsp_ready`=1.

## Configuration
- Macro `ADDER_ARB_LOCK_EN`.
- Defined:
  - An accept with `req_lock[g]`=1 sets lock owner = g and freezes `ptr` at g.
  - While locked, only the owner can win. Other requesters see `req_ready`=0 even when the owner is idle.
  - The first accept of the owner with `req_lock`=0 clears the lock and sets `ptr` to g+1.
  - The lock supports multi-word chained operations.
- Undefined: `req_lock` is ignored and arbitration is pure round-robin.

## Test plan
- Reset then single op: req 2 with A=0xFFFFFFFF, B=0x00000001, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=0, `rsp_carry`=1; `ops_count`=1 after the handshake.
- All four requesters valid continuously with `rsp_ready`=1 → grant order 0,1,2,3,0 on consecutive cycles, one response per cycle.
- Hold `rsp_ready`=0 after one accept for 5 cycles → `rsp_valid` stays 1 with data stable and all `req_ready`=0. Raising `rsp_ready` gives a drain and a new accept on the same edge.
- Assert `rst` on the edge where FULL and `rsp_ready`=1 coincide with a new accept → all outputs are 0 next cycle and `ops_count`=0.
- `ops_count` preloaded by running 65536 responses → reads 0 (wrap).
- With `ADDER_ARB_LOCK_EN`: req 1 issues 3 locked ops while req 0 and req 3 are valid → ids 1,1,1. An unlocked op from req 1 follows, then grants go 3,0.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit recursive-doubling adder among NREQ requesters.
// Optional owner lock for chained multi-word operations: define ADDER_ARB_LOCK_EN.
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_carry,
  output logic [15:0]          ops_count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]     state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] id_reg;
  logic [31:0]    sum_reg;
  logic           carry_reg;
  logic [15:0]    ops_reg;

  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  win;
  logic            found;
  logic            can_accept;
  logic            grant;
  logic [IDW-1:0]  win_inc;
  logic [31:0]     a_arr [NREQ];
  logic [31:0]     b_arr [NREQ];
  logic [IDW-1:0]  scan_idx [NREQ];
  logic [31:0]     a_sel;
  logic [31:0]     b_sel;
  logic [31:0]     sum_next;
  logic            carry_next;

`ifdef ADDER_ARB_LOCK_EN
  logic           lock_reg;
  logic [IDW-1:0] owner_reg;

  // While locked, only the owner is eligible, even if it is idle.
  assign elig = lock_reg ? (req_valid & (NREQ'(1) << owner_reg)) : req_valid;
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign elig        = req_valid;
`endif

  genvar gi;
  genvar gl;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [IDW:0] pos;

      assign a_arr[gi]    = req_a[32*gi +: 32];
      assign b_arr[gi]    = req_b[32*gi +: 32];
      assign pos          = {1'b0, ptr_reg} + (IDW+1)'(gi);
      assign scan_idx[gi] = (pos >= (IDW+1)'(NREQ)) ? IDW'(pos - (IDW+1)'(NREQ)) : pos[IDW-1:0];
    end
  endgenerate

  // Scan from the farthest offset back to ptr so the nearest eligible requester wins.
  always_comb begin
    win   = ptr_reg;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[scan_idx[k]]) begin
        win   = scan_idx[k];
        found = 1'b1;
      end
    end
  end

  assign rsp_valid  = (state_reg == ST_FULL);
  assign can_accept = !rsp_valid || rsp_ready;
  assign grant      = can_accept && found;
  assign req_ready  = grant ? (NREQ'(1) << win) : '0;
  assign win_inc    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign a_sel      = a_arr[win];
  assign b_sel      = b_arr[win];

  // Kogge-Stone style prefix adder with carry-in of zero.
  logic [5:0][31:0] gen_l;
  logic [4:0][31:0] prop_l;
  logic             unused_prop;

  assign gen_l[0]  = a_sel & b_sel;
  assign prop_l[0] = a_sel ^ b_sel;

  generate
    for (gl = 0; gl < 5; gl++) begin : g_lvl
      for (gi = 0; gi < 32; gi++) begin : g_bit
        if (gi >= (1 << gl)) begin : g_combine
          assign gen_l[gl+1][gi] = gen_l[gl][gi] | (prop_l[gl][gi] & gen_l[gl][gi-(1<<gl)]);
          if (gl < 4) begin : g_prop
            assign prop_l[gl+1][gi] = prop_l[gl][gi] & prop_l[gl][gi-(1<<gl)];
          end
        end else begin : g_pass
          assign gen_l[gl+1][gi] = gen_l[gl][gi];
          if (gl < 4) begin : g_prop
            assign prop_l[gl+1][gi] = prop_l[gl][gi];
          end
        end
      end
    end
  endgenerate

  assign unused_prop = ^prop_l[4][15:0];
  assign sum_next    = prop_l[0] ^ {gen_l[5][30:0], 1'b0};
  assign carry_next  = gen_l[5][31];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      ptr_reg   <= '0;
      id_reg    <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      ops_reg   <= '0;
`ifdef ADDER_ARB_LOCK_EN
      lock_reg  <= 1'b0;
      owner_reg <= '0;
`endif
    end else begin
      if (rsp_valid && rsp_ready) begin
        ops_reg <= ops_reg + 16'd1;
      end
      if (grant) begin
        state_reg <= ST_FULL;
        id_reg    <= win;
        sum_reg   <= sum_next;
        carry_reg <= carry_next;
`ifdef ADDER_ARB_LOCK_EN
        if (req_lock[win]) begin
          lock_reg  <= 1'b1;
          owner_reg <= win;
          ptr_reg   <= win;
        end else begin
          lock_reg  <= 1'b0;
          ptr_reg   <= win_inc;
        end
`else
        ptr_reg   <= win_inc;
`endif
      end else if (rsp_valid && rsp_ready) begin
        state_reg <= ST_EMPTY;
      end
    end
  end

  assign rsp_id    = id_reg;
  assign rsp_sum   = sum_reg;
  assign rsp_carry = carry_reg;
  assign ops_count = ops_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: scoreboard monitor plus per-scenario tasks.
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*32-1:0]   req_a = '0;
  logic [NREQ*32-1:0]   req_b = '0;
  logic [NREQ-1:0]      req_lock = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_sum;
  logic                 rsp_carry;
  logic [15:0]          ops_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [32:0]    sum;
  } exp_t;

  exp_t sb[$];

  // Reference model state, advanced once per cycle at the falling edge.
  bit          m_full = 1'b0;
  int          m_ptr = 0;
  bit          m_locked = 1'b0;
  int          m_owner = 0;
  logic [15:0] m_ops = '0;
  logic [3:0]  m_elig;
  logic [3:0]  m_exp_ready;
  int          m_w;
  bit          m_found;
  bit          m_can;
  exp_t        m_e;

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .ops_count (ops_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_full   = 1'b0;
      m_ptr    = 0;
      m_locked = 1'b0;
      m_owner  = 0;
      m_ops    = '0;
    end else begin
      m_elig  = m_locked ? (req_valid & (4'b0001 << m_owner)) : req_valid;
      m_found = 1'b0;
      m_w     = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!m_found && m_elig[(m_ptr + k) % NREQ]) begin
          m_w     = (m_ptr + k) % NREQ;
          m_found = 1'b1;
        end
      end
      m_can       = !m_full || rsp_ready;
      m_exp_ready = (m_can && m_found) ? (4'b0001 << m_w) : 4'b0000;

      total++;
      if (req_ready !== m_exp_ready) begin
        bad++;
        $display("FAIL sb_req_ready got=%b exp=%b t=%0t", req_ready, m_exp_ready, $time);
      end
      total++;
      if (rsp_valid !== m_full) begin
        bad++;
        $display("FAIL sb_rsp_valid got=%b exp=%b t=%0t", rsp_valid, m_full, $time);
      end
      total++;
      if (ops_count !== m_ops) begin
        bad++;
        $display("FAIL sb_ops_count got=%h exp=%h t=%0t", ops_count, m_ops, $time);
      end
      if (m_full) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_empty no expected entry for rsp_id=%0d t=%0t", rsp_id, $time);
        end else begin
          m_e = sb[0];
          if ({rsp_id, rsp_carry, rsp_sum} !== {m_e.id, m_e.sum}) begin
            bad++;
            $display("FAIL sb_rsp got id=%0d c=%b s=%h exp id=%0d c=%b s=%h t=%0t",
                     rsp_id, rsp_carry, rsp_sum, m_e.id, m_e.sum[32], m_e.sum[31:0], $time);
          end
        end
      end
      if (m_full && rsp_ready) begin
        m_ops = m_ops + 16'd1;
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (m_can && m_found) begin
        m_e.id  = IDW'(m_w);
        m_e.sum = {1'b0, req_a[m_w*32 +: 32]} + {1'b0, req_b[m_w*32 +: 32]};
        sb.push_back(m_e);
        m_full = 1'b1;
`ifdef ADDER_ARB_LOCK_EN
        if (req_lock[m_w]) begin
          m_locked = 1'b1;
          m_owner  = m_w;
          m_ptr    = m_w;
        end else begin
          m_locked = 1'b0;
          m_ptr    = (m_w + 1) % NREQ;
        end
`else
        m_ptr = (m_w + 1) % NREQ;
`endif
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    total++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_carry, ops_count, req_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b id=%0d s=%h c=%b ops=%h rdy=%b exp all zero",
               rsp_valid, rsp_id, rsp_sum, rsp_carry, ops_count, req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
    req_valid = 4'b0100;
    cyc();
    total++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'd2, 32'h0, 1'b1}) begin
      bad++;
      $display("FAIL single_rsp got v=%b id=%0d s=%h c=%b exp v=1 id=2 s=0 c=1",
               rsp_valid, rsp_id, rsp_sum, rsp_carry);
    end
    req_valid = 4'b0000;
    cyc();
    total++;
    if (ops_count !== 16'd1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_count got ops=%0d v=%b exp ops=1 v=0", ops_count, rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      set_op(i, 32'h1000_0000 * i + 32'd17, 32'hF000_0001 - 32'd3 * i);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(k % NREQ)) begin
        bad++;
        $display("FAIL rr_order step=%0d got v=%b id=%0d exp v=1 id=%0d", k, rsp_valid, rsp_id, k % NREQ);
      end
    end
    req_valid = 4'b0000;
    cyc();
  endtask

  task automatic test_back_to_back();
    set_op(1, 32'h1234_5678, 32'h1111_1111);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    cyc();
    set_op(1, 32'h0000_0005, 32'h0000_0006);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'h2345_6789 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL hold cyc=%0d got v=%b s=%h id=%0d rdy=%b exp v=1 s=23456789 id=1 rdy=0000",
                 k, rsp_valid, rsp_sum, rsp_id, req_ready);
      end
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL release_ready got=%b exp=0100", req_ready);
    end
    cyc();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
      bad++;
      $display("FAIL drain_accept got v=%b id=%0d exp v=1 id=2", rsp_valid, rsp_id);
    end
    req_valid = 4'b0000;
    cyc();
    cyc();
  endtask

  task automatic test_reset_midstream();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    total++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_carry, ops_count} !== '0) begin
      bad++;
      $display("FAIL rst_midstream got v=%b id=%0d s=%h c=%b ops=%h exp all zero",
               rsp_valid, rsp_id, rsp_sum, rsp_carry, ops_count);
    end
    rst = 1'b0;
    req_valid = 4'b0000;
    cyc();
  endtask

  task automatic test_wrap();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (65536) cyc();
    req_valid = 4'b0000;
    total++;
    if (ops_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_pre got=%h exp=ffff", ops_count);
    end
    cyc();
    total++;
    if (ops_count !== 16'h0000 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL wrap got ops=%h v=%b exp ops=0000 v=0", ops_count, rsp_valid);
    end
  endtask

`ifdef ADDER_ARB_LOCK_EN
  task automatic test_lock();
    int exp_ids[3] = '{1, 1, 1};
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_op(0, 32'hA, 32'hB);
    set_op(3, 32'h3000_0000, 32'h0000_0003);
    req_lock  = 4'b0010;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      set_op(1, 32'hFFFF_0000 + k, 32'h0001_0000);
      cyc();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_ids[k])) begin
        bad++;
        $display("FAIL lock_op k=%0d got v=%b id=%0d exp v=1 id=1", k, rsp_valid, rsp_id);
      end
      req_valid = 4'b1011;
    end
    req_valid = 4'b1001;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL lock_idle_owner got rdy=%b exp=0000", req_ready);
    end
    cyc();
    req_valid = 4'b1011;
    req_lock  = 4'b0000;
    set_op(1, 32'h7, 32'h8);
    cyc();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      bad++;
      $display("FAIL unlock_op got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id);
    end
    req_valid = 4'b1001;
    cyc();
    total++;
    if (rsp_id !== 2'd3) begin
      bad++;
      $display("FAIL after_unlock_1 got id=%0d exp=3", rsp_id);
    end
    cyc();
    total++;
    if (rsp_id !== 2'd0) begin
      bad++;
      $display("FAIL after_unlock_2 got id=%0d exp=0", rsp_id);
    end
    req_valid = 4'b0000;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_reset_midstream();
    test_wrap();
`ifdef ADDER_ARB_LOCK_EN
    test_lock();
`endif
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
